// File: rtl/srl_fifo_ctl_pkg.sv
// srl_fifo_ctl_pkg: shared storage sizes and word type for the SRL-based FIFO
package srl_fifo_ctl_pkg;
  localparam int SRL_DEPTH = 16;
  localparam int CNT_W = 5;
  typedef logic [15:0] word_t;
endpackage

// File: rtl/srl_fifo_ctl_srl16x16e.sv
// srl16x16e: 16-stage x 16-bit addressable shift register, new word enters at stage 0
module srl16x16e
  import srl_fifo_ctl_pkg::*;
(
  input  logic       clk,
  input  logic       ce,
  input  logic [3:0] a,
  input  word_t      d,
  output word_t      y
);
  word_t sr [SRL_DEPTH];
  always_ff @(posedge clk) begin
    if (ce) begin
      sr[0] <= d;
      for (int i = 1; i < SRL_DEPTH; i++) sr[i] <= sr[i-1];
    end
  end
  assign y = sr[a];
endmodule

// File: rtl/srl_fifo_ctl.sv
// srl_fifo_ctl: ready/valid FIFO controller over srl16x16e with registered output word.
// Define SRL_FIFO_LEVEL_EN to expose the shift-register occupancy on the level port.
module srl_fifo_ctl
  import srl_fifo_ctl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AFULL = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             afull
`ifdef SRL_FIFO_LEVEL_EN
  ,
  output logic [CNT_W-1:0] level
`endif
);
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic push, load, pop_out;
  word_t y;
  assign in_ready = cnt != CNT_W'(SRL_DEPTH);
  assign push = in_valid & in_ready;
  assign pop_out = out_valid & out_ready;
  assign load = (cnt != '0) & (~out_valid | out_ready);
  always_comb cnt_nxt = (push & ~load) ? cnt + CNT_W'(1) : (load & ~push) ? cnt - CNT_W'(1) : cnt;
  // oldest word always sits at cnt-1; a same-cycle shift moves the next-oldest into that slot
  srl16x16e u_srl (
    .clk,
    .ce(push),
    .a (cnt[3:0] - 4'd1),
    .d (in_data),
    .y
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      afull <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      cnt <= cnt_nxt;
      afull <= cnt_nxt >= CNT_W'(AFULL);
      if (load) begin
        out_data <= y;
        out_valid <= 1'b1;
      end else if (pop_out) begin
        out_valid <= 1'b0;
      end
    end
  end
`ifdef SRL_FIFO_LEVEL_EN
  assign level = cnt;
`endif
endmodule

// File: tb/tb_srl_fifo_ctl.sv
// tb_srl_fifo_ctl: queue-based reference model checked every cycle plus directed literal checks
module tb_srl_fifo_ctl;
  import srl_fifo_ctl_pkg::*;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  word_t in_data = '0;
  logic in_ready, out_valid, afull;
  logic [15:0] out_data;
`ifdef SRL_FIFO_LEVEL_EN
  logic [CNT_W-1:0] level;
`endif
  int n_vec = 0, n_err = 0;
  bit started = 0;
  word_t m_q[$];
  logic m_ov = 0;
  word_t m_od = '0;

  srl_fifo_ctl dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .afull(afull)
`ifdef SRL_FIFO_LEVEL_EN
    , .level(level)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: words in the shift register as a queue, plus the output register
  task automatic cycle(input logic iv, input word_t d, input logic ordy, output logic acc);
    logic p, l;
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    p = iv && (m_q.size() != SRL_DEPTH);
    l = (m_q.size() != 0) && (!m_ov || ordy);
    acc = p;
    @(posedge clk);
    if (l) begin
      m_od = m_q.pop_front();
      m_ov = 1;
    end else if (m_ov && ordy) m_ov = 0;
    if (p) m_q.push_back(d);
    #1;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ov = 0;
    m_od = '0;
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", int'(in_ready), int'(m_q.size() != SRL_DEPTH));
      chk("out_valid", int'(out_valid), int'(m_ov));
      chk("out_data", int'(out_data), int'(m_od));
      chk("afull", int'(afull), int'(m_q.size() >= 12));
      chk("cnt", int'(dut.cnt), m_q.size());
      chk("cnt_bound", int'(dut.cnt <= 5'd16), 1);
`ifdef SRL_FIFO_LEVEL_EN
      chk("level", int'(level), m_q.size());
`endif
    end
  end

  initial begin
    logic acc, iv;
    word_t d;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    started = 1;
    // 1: reset values, single push latency
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_afull", int'(afull), 0);
    cycle(1, 16'hA5A5, 0, acc);
    chk("t1_ov_edge1", int'(out_valid), 0);
    cycle(0, 16'h0, 0, acc);
    chk("t1_ov_edge2", int'(out_valid), 1);
    chk("t1_data", int'(out_data), 16'hA5A5);
    chk("t1_cnt", int'(dut.cnt), 0);
    cycle(0, 16'h0, 1, acc);
    chk("t1_popped", int'(out_valid), 0);
    // 2: fill 17 words, then drain in order
    for (int i = 1; i <= 17; i++) cycle(1, word_t'(i), 0, acc);
    in_valid = 0;
    chk("t2_in_ready", int'(in_ready), 0);
    chk("t2_cnt", int'(dut.cnt), 16);
    chk("t2_afull", int'(afull), 1);
    chk("t2_head", int'(out_data), 1);
    for (int i = 1; i <= 17; i++) begin
      cycle(0, 16'h0, 1, acc);
      if (i < 17) begin
        chk("t2_drain_valid", int'(out_valid), 1);
        chk("t2_drain_data", int'(out_data), i + 1);
      end else chk("t2_drain_end", int'(out_valid), 0);
    end
    // 3: streaming from empty, then from cnt = 5
    for (int i = 0; i < 20; i++) cycle(1, word_t'(16'h0200 + i), 1, acc);
    chk("t3_cnt0_start", int'(dut.cnt), 1);
    for (int i = 0; i < 5; i++) cycle(0, 16'h0, 1, acc);
    for (int i = 0; i < 6; i++) cycle(1, word_t'(16'h0300 + i), 0, acc);
    chk("t3_cnt5", int'(dut.cnt), 5);
    for (int i = 6; i < 26; i++) cycle(1, word_t'(16'h0300 + i), 1, acc);
    chk("t3_cnt5_hold", int'(dut.cnt), 5);
    chk("t3_order", int'(out_data), 16'h0314);
    for (int i = 0; i < 8; i++) cycle(0, 16'h0, 1, acc);
    // 4: full with held in_valid
    for (int i = 0; i < 17; i++) cycle(1, word_t'(16'h0400 + i), 0, acc);
    cycle(1, 16'h0500, 1, acc);
    chk("t4_blocked", int'(acc), 0);
    chk("t4_ready_back", int'(in_ready), 1);
    chk("t4_next_head", int'(out_data), 16'h0401);
    cycle(1, 16'h0500, 1, acc);
    chk("t4_accepted", int'(acc), 1);
    for (int i = 0; i < 20; i++) cycle(0, 16'h0, 1, acc);
    chk("t4_last_word", int'(out_data), 16'h0500);
    // 5: random traffic with held valid/data
    iv = 0;
    d = '0;
    acc = 0;
    for (int i = 0; i < 10000; i++) begin
      if (!iv || acc) begin
        iv = 1'($urandom_range(0, 1));
        d = word_t'($urandom);
      end
      cycle(iv, d, (i < 5000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0), acc);
    end
    for (int i = 0; i < 20; i++) cycle(0, 16'h0, 1, acc);
    // 6: async reset with cnt = 9, out_valid = 1
    for (int i = 0; i < 10; i++) cycle(1, word_t'(16'h0600 + i), 0, acc);
    in_valid = 0;
    chk("t6_pre_cnt", int'(dut.cnt), 9);
    chk("t6_pre_ov", int'(out_valid), 1);
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("t6_rst_ov", int'(out_valid), 0);
    chk("t6_rst_afull", int'(afull), 0);
    chk("t6_rst_cnt", int'(dut.cnt), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    cycle(1, 16'h1234, 0, acc);
    cycle(0, 16'h0, 0, acc);
    chk("t6_first_out", int'(out_data), 16'h1234);
    chk("t6_first_valid", int'(out_valid), 1);
    @(negedge clk);
    started = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/srl_fifo_ctl.md
Name: srl_fifo_ctl

Overview:
- Synchronous FIFO built on the 16-stage × 16-bit addressable shift register `srl16x16e`.
- This block owns the write/read handshakes and the occupancy counter. It drives the shift-register `ce` and `a` controls and registers the output word.
- It sits between DSP pipeline stages that need elastic buffering with ready/valid flow control. Total capacity is 17 words: 16 in the shift register plus 1 in the output register.

Parameters:
- WIDTH, 16, data width. Only 16 is supported, matching the shift-register width.
- AFULL, 12, occupancy at or above which `afull` asserts. Counts shift-register entries only (0..16).

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  16  write data
- in_valid  in  1  write request
- in_ready  out  1  controller can accept a word
- out_data  out  16  registered head-of-FIFO word
- out_valid  out  1  `out_data` holds a valid word
- out_ready  in  1  downstream accepts `out_data`
- afull  out  1  occupancy ≥ AFULL
- level  out  5  shift-register occupancy 0..16 (only with `SRL_FIFO_LEVEL_EN`)

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous, active-low.
- Reset values:
  - cnt = 0, out_valid = 0, out_data = 0, afull = 0, level = 0.
  - in_ready = 1 once `rst_n` is released.
  - Shift-register contents are not reset and are never observed while cnt = 0.
- Internal state:
  - cnt[4:0]: number of words held in the shift register.
  - Output register: out_data and out_valid.
- Shift-register controls:
  - ce = push.
  - a = cnt − 1 (low 4 bits), so a always points at the oldest word. When cnt = 0, a is don't-care.
  - d = in_data.
- push = in_valid & in_ready, with in_ready = (cnt != 16). in_ready is decoded from registered cnt only. There is no combinational path from out_ready to in_ready.
- pop_out = out_valid & out_ready.
- load = (cnt != 0) & (!out_valid | out_ready). On load, out_data ← y (the word at address cnt−1) and out_valid ← 1.
- If pop_out & !load, then out_valid ← 0 and out_data holds its value.
- cnt update:
  - push & !load: cnt + 1
  - load & !push: cnt − 1
  - push & load, or neither: cnt unchanged
- Push and load in the same cycle: the shift-register read of word cnt−1 completes before the clock edge. After the shift, the next-oldest word is again at cnt−1, so no address correction is needed.
- Latency:
  - A word accepted at edge N into an empty FIFO appears with out_valid = 1 after edge N+1.
  - With the output register full and cnt > 0, back-to-back pops sustain 1 word/cycle.
  - Steady-state throughput is 1 word/cycle with simultaneous push and pop.
- Full: cnt = 16 ⇒ in_ready = 0. in_valid is ignored and must be held by the source. in_ready returns to 1 the cycle after a load.
- Empty: cnt = 0 and out_valid = 0. out_ready is ignored. A push into an empty FIFO is not bypassed to the output (2-cycle minimum latency).
- afull = (cnt ≥ AFULL), registered from next-cnt so it is aligned with cnt.
- Reset mid-operation: all stored words are discarded. Handshake outputs go to their reset values immediately (asynchronous assert); release is synchronous to clk.
- cnt never exceeds 16 or wraps below 0. The verification bench asserts this.

Optional Feature:
- Macro: `SRL_FIFO_LEVEL_EN`.
- Defined: the `level` port exists and equals registered cnt (0..16). The out_valid word is excluded.
- Undefined: the `level` port is absent and cnt stays internal. All other behaviour is identical.

Decomposition:
- Shared package: SRL_DEPTH = 16, CNT_W = 5, and the word type (16-bit logic vector).
- One sub-module: `srl16x16e`, instantiated once as the storage. The controller logic stays flat in srl_fifo_ctl.

Test Plan:
1. Reset, then a single push of 16'hA5A5 with out_ready = 0:
   - out_valid = 1 after two edges, out_data = A5A5.
   - level = 0 after the load.
2. Fill to full: push 17 words 0x0001..0x0011 with out_ready = 0:
   - in_ready = 0 after the 17th accept, level = 16, afull = 1 from cnt = 12.
   - Drain with out_ready = 1: output order is 1..17, no gaps, out_valid then drops.
3. Continuous streaming at 1 word/cycle (push and pop every cycle):
   - cnt stays constant and data order is preserved.
   - Test with cnt = 0 startup, then with cnt = 5 startup.
4. Full FIFO with out_ready = 1 and in_valid held:
   - in_ready rises one cycle after the pop.
   - The next word lands at position 16, and no word is lost or duplicated.
5. Random valid/ready (10k cycles) against a scoreboard queue:
   - Exact data match.
   - cnt always within 0..16.
   - out_data stable while out_valid & !out_ready.
6. Assert rst_n low with cnt = 9 and out_valid = 1:
   - out_valid = 0 and afull = 0 immediately.
   - After release, the first new push of 16'h1234 is the first word out.
